pipelined_addsub: RTL
=====================

# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor and the successor to the fixed 4-bit ripple adder. The WIDTH-bit carry chain is split into STAGES equal chunks with one register stage per chunk, so clock rate scales with chunk width rather than full width. A valid/ready handshake at both ends allows one operation per cycle with backpressure. It sits between operand producers (register file, accumulators) and any consumer needing sum, carry-out and signed overflow.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of STAGES (elaboration error otherwise).
- STAGES, 4: pipeline depth; chunk width CW = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH.

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: add, 1: subtract
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- overflow  out  1  signed overflow

## Operation
- Effective operands: B' = sub ? ~b : b; c0 = sub ? ~cin : cin. Result = a + B' + c0, mod 2^WIDTH.
  - Add: sum = a + b + cin.
  - Sub: sum = a − b − cin.
- cout = carry out of bit WIDTH−1 of a + B' + c0.
- overflow = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Stage k (0..STAGES−1) adds chunk k of a and B' plus the carry registered by stage k−1 (stage 0 uses c0).
  - It registers chunk k of the result and the chunk carry.
  - Higher operand chunks travel in skew registers; completed lower result chunks travel in deskew registers.
- The final stage also registers the carry into the MSB for the overflow computation.
- Each stage carries a valid bit. Bubbles (in_valid=0) propagate as invalid slots; result order equals acceptance order.
- Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv. This is a combinational path from out_ready; no skid buffer.
  - When adv=0, every stage register holds, including valid bits.
  - When adv=1, all stages shift by one and stage 0 loads {in_valid, operands}.
- Accept: an edge with in_valid && in_ready. Deliver: an edge with out_valid && out_ready.
- Reset (rst=1 at an edge): all valid bits clear, and all data, carry and output registers clear.
  - Outputs after reset: out_valid=0, sum=0, cout=0, overflow=0; in_ready=1.
  - In-flight operations are discarded, never delivered.
- rst has priority over accept and advance in the same cycle.

## Timing
- Latency: STAGES edges from accept to out_valid=1, provided no stall occurs. Each cycle with adv=0 adds one cycle.
- Throughput: one op/cycle while out_ready=1.
- sum, cout, overflow and out_valid are registered and stay stable while out_valid && !out_ready.
- Inputs are sampled only on accepting edges; inputs when in_ready=0 are ignored (producer must hold).
- Simultaneous deliver and accept in the same cycle is legal and loses no slot.
- STAGES=1: a single register stage, latency 1, no skew registers.
- Longest combinational path: a CW-bit add plus carry mux, plus the out_ready→in_ready path.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0, sum=0x0000, cout=0, overflow=0, in_ready=1; nothing emerges afterwards.
- Full carry ripple (WIDTH=16, STAGES=4): a=0xFFFF, b=0x0001, cin=0, sub=0 → exactly 4 cycles later sum=0x0000, cout=1, overflow=0.
- Subtract overflow: a=0x8000, b=0x0001, sub=1, cin=0 → sum=0x7FFF, cout=1, overflow=1.
- Borrow case: a=0x0000, b=0x0001, sub=1, cin=1 → sum=0xFFFE, cout=0, overflow=0.
- Streaming with backpressure: 8 back-to-back ops a=i, b=0x0100·i with out_ready=1 → 8 results on consecutive cycles, in order. Then drop out_ready for 3 cycles mid-stream → in_ready=0, sum held, no loss or duplication; a bubble inserted at input 5 appears as one out_valid=0 gap.
- Reset mid-flight plus minimum depth: 3 ops in flight, assert rst 1 cycle → out_valid=0 next cycle and no stale results. Separately, WIDTH=8, STAGES=1: a=0x7F, b=0x01 → after 1 cycle sum=0x80, overflow=1, cout=0.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: the WIDTH-bit carry chain is cut
// into STAGES chunks, one register stage per chunk, with a global stall enable.
module pipelined_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int CW  = WIDTH / STAGES;
   localparam int CW1 = CW + 1;

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   // Per-stage registers: operands ride along (skew) until their chunk is
   // consumed, finished result chunks ride along (deskew) until the output.
   logic [WIDTH-1:0] op_a  [STAGES];
   logic [WIDTH-1:0] op_b  [STAGES];
   logic [WIDTH-1:0] res   [STAGES];
   logic             carry [STAGES];
   logic [STAGES:1]  vld_pipe;
   logic             ovf_q;

   logic [WIDTH-1:0] src_a [STAGES];
   logic [WIDTH-1:0] src_b [STAGES];
   logic [WIDTH-1:0] src_r [STAGES];
   logic             src_c [STAGES];
   logic [WIDTH-1:0] nxt_r [STAGES];
   logic             nxt_c [STAGES];
   logic [CW:0]      part  [STAGES];
   logic             msb_cin;
   logic             adv;

   always_comb begin
      // Subtract is folded in up front so every stage is a plain adder.
      src_a[0] = a;
      src_b[0] = b ^ {WIDTH{sub}};
      src_r[0] = '0;
      src_c[0] = cin ^ sub;
      for (int k = 1; k < STAGES; k++) begin
         src_a[k] = op_a[k-1];
         src_b[k] = op_b[k-1];
         src_r[k] = res[k-1];
         src_c[k] = carry[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         part[k]  = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
                    + CW1'(src_c[k]);
         nxt_r[k] = src_r[k];
         nxt_r[k][k*CW +: CW] = part[k][CW-1:0];
         nxt_c[k] = part[k][CW];
      end
      // Carry into the MSB recovered from the MSB sum bit and its operands.
      msb_cin = part[STAGES-1][CW-1] ^ src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1];
   end

   assign out_valid = vld_pipe[STAGES];
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign sum       = res[STAGES-1];
   assign cout      = carry[STAGES-1];
   assign overflow  = ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            op_a[k]  <= '0;
            op_b[k]  <= '0;
            res[k]   <= '0;
            carry[k] <= 1'b0;
         end
         vld_pipe <= '0;
         ovf_q    <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            op_a[k]  <= src_a[k];
            op_b[k]  <= src_b[k];
            res[k]   <= nxt_r[k];
            carry[k] <= nxt_c[k];
         end
         vld_pipe[1] <= in_valid;
         for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
         ovf_q <= nxt_c[STAGES-1] ^ msb_cin;
      end
   end
endmodule
